// File: rtl/rv_pkg.sv
// Shared encodings for the multicycle RV32 datapath and its control FSM.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RAW  = 5;

  typedef enum logic {
    PC_INC = 1'b0,
    PC_ALU = 1'b1
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_PC     = 2'd0,
    WB_ALUOUT = 2'd1,
    WB_MDR    = 2'd2,
    WB_ZERO   = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    IMM_L = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } imm_sel_e;

  typedef enum logic [1:0] {
    ALUA_REG    = 2'd0,
    ALUA_PCC    = 2'd1,
    ALUA_ALUOUT = 2'd2,
    ALUA_ZERO   = 2'd3
  } alua_sel_e;

  typedef enum logic [1:0] {
    ALUB_REG   = 2'd0,
    ALUB_IMM   = 2'd1,
    ALUB_TOXOR = 2'd2,
    ALUB_ZERO  = 2'd3
  } alub_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0110,
    ALU_XOR  = 4'b1000,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_OR   = 4'b1100,
    ALU_AND  = 4'b1110
  } alu_op_e;

endpackage

// File: rtl/rv_alu.sv
// Combinational ALU; unlisted operation codes fall back to ADD.
module rv_alu
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alusel,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = a + b;
    case (alusel)
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result = XLEN'(a < b);
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = a + b;
    endcase
  end

endmodule

// File: rtl/rv_dp.sv
// Multicycle RV32 datapath: PC/PCC/IR/MDR/ALUOUT, inline register file,
// immediate generation and operand muxing around rv_alu.
module rv_dp
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            pcsourse,
  input  logic            pcwrite,
  input  logic            pccen,
  input  logic            irwrite,
  input  logic [1:0]      wbsel,
  input  logic            regwen,
  input  logic [1:0]      immsel,
  input  logic [1:0]      asel,
  input  logic [1:0]      bsel,
  input  logic [3:0]      alusel,
  input  logic            mdrwrite,
  output logic [XLEN-1:0] instr,
  output logic            zero,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcc_q, pcc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] mdr_q, mdr_d;
  logic [XLEN-1:0] aluout_q, aluout_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];

  logic [RAW-1:0]  rs1, rs2, rd;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, alu_a, alu_b, alu_res, wb_data;

  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign rd       = ir_q[11:7];
  assign rs1_data = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_data = (rs2 == '0) ? '0 : rf_q[rs2];

  assign instr     = ir_q;
  assign mem_wdata = rs2_data;
  assign mem_addr  = irwrite ? pc_q : aluout_q;
  assign zero      = (alu_res == '0);

  // Immediate formats, all sign-extended from ir_q[31]
  always_comb begin
    imm = {{20{ir_q[31]}}, ir_q[31:20]};
    case (immsel)
      IMM_S:   imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      IMM_B:   imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      IMM_J:   imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: imm = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (asel)
      ALUA_REG:    alu_a = rs1_data;
      ALUA_PCC:    alu_a = pcc_q;
      ALUA_ALUOUT: alu_a = aluout_q;
      default:     alu_a = '0;
    endcase
    case (bsel)
      ALUB_REG:   alu_b = rs2_data;
      ALUB_IMM:   alu_b = imm;
      ALUB_TOXOR: alu_b = '1;
      default:    alu_b = '0;
    endcase
  end

  rv_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alusel (alusel),
    .result (alu_res)
  );

  always_comb begin
    wb_data = '0;
    case (wbsel)
      WB_PC:     wb_data = pc_q;
      WB_ALUOUT: wb_data = aluout_q;
      WB_MDR:    wb_data = mdr_q;
      default:   wb_data = '0;
    endcase
  end

  // Next-state for architectural registers; writes to x0 are dropped
  always_comb begin
    pc_d     = pc_q;
    pcc_d    = pcc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    aluout_d = alu_res;
    rf_d     = rf_q;
    if (pcwrite)  pc_d  = (pcsourse == PC_ALU) ? alu_res : pc_q + XLEN'(4);
    if (pccen)    pcc_d = pc_q;
    if (irwrite)  ir_d  = mem_rdata;
    if (mdrwrite) mdr_d = mem_rdata;
    if (regwen && (rd != '0)) rf_d[rd] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      pcc_q    <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      aluout_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      pcc_q    <= pcc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      aluout_q <= aluout_d;
      rf_q     <= rf_d;
    end
  end

endmodule

// File: doc/rv_dp.md
RV_DP -- requirements
Module: rv_dp

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-003 SHALL have control inputs from the control FSM: pcsourse 1, pcwrite 1, pccen 1, irwrite 1, wbsel 2, regwen 1, immsel 2, asel 2, bsel 2, alusel 4, mdrwrite 1.
REQ-004 SHALL have port instr, output, 32, IR contents for the control FSM.
REQ-005 SHALL have port zero, output, 1; combinational; high when ALU result == 0.
REQ-006 SHALL have port mem_addr, output, 32; memory address.
REQ-007 SHALL have port mem_wdata, output, 32; store data.
REQ-008 SHALL have port mem_rdata, input, 32; asynchronous-read memory data, valid in the same cycle as mem_addr.

Function
REQ-009 SHALL hold registers PC, PCC (current-instruction PC), IR, MDR, ALUOUT and a 32x32 register file.
REQ-010 mem_addr SHALL equal PC when irwrite=1, else ALUOUT.
REQ-011 IR SHALL load mem_rdata when irwrite=1; otherwise hold.
REQ-012 PCC SHALL load PC when pccen=1; otherwise hold.
REQ-013 PC SHALL load when pcwrite=1: PC+4 if pcsourse=PC_INC(0), ALU result if pcsourse=PC_ALU(1). Otherwise PC holds. Addition wraps modulo 2^32.
REQ-014 MDR SHALL load mem_rdata when mdrwrite=1.
REQ-015 ALUOUT SHALL load the ALU result every cycle, unconditionally.
REQ-016 Register file reads SHALL be asynchronous: rs1=instr[19:15], rs2=instr[24:20]; x0 always reads 0.
REQ-017 Register write SHALL occur on clk edge when regwen=1, rd=instr[11:7]; rd=0 SHALL be ignored.
REQ-018 Write data SHALL be selected by wbsel: WB_PC(0)=PC, WB_ALUOUT(1)=ALUOUT, WB_MDR(2)=MDR, 3=0.
REQ-019 A same-cycle read of the register being written SHALL return the old value; the new value is visible next cycle.
REQ-020 Immediates SHALL be sign-extended from instr[31] per immsel:
- IMM_L(0): instr[31:20]
- IMM_S(1): {instr[31:25],instr[11:7]}
- IMM_B(2): {instr[7],instr[30:25],instr[11:8],0}
- IMM_J(3): {instr[19:12],instr[20],instr[30:21],0}
REQ-021 ALU operand A SHALL be selected by asel: ALUA_REG(0)=rs1 data, ALUA_PCC(1)=PCC, ALUA_ALUOUT(2)=ALUOUT, 3=0.
REQ-022 ALU operand B SHALL be selected by bsel: ALUB_REG(0)=rs2 data, ALUB_IMM(1)=immediate, ALUB_TOXOR(2)=32'hFFFF_FFFF, 3=0.
REQ-023 ALU operation SHALL be selected by alusel:
- ADD 0000, SUB 0001, SLL 0010, SLT 0100 (signed), SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110
- any other code performs ADD
- shift amount is B[4:0]
- SLT/SLTU return 0 or 1
REQ-024 mem_wdata SHALL equal rs2 read data.
REQ-025 When pcwrite and irwrite are both 1, IR SHALL capture data from the old PC and PC SHALL update in the same edge.

Reset
REQ-026 With rst=1 at a clk edge, PC, PCC, IR, MDR, ALUOUT and all register-file entries SHALL become 0; reset overrides every enable.
REQ-027 Reset asserted mid-instruction SHALL discard all partial state. After release, the first fetch SHALL use address 0.

Structure
REQ-028 Encodings SHALL live in shared package rv_pkg, also used by the control FSM: PC_*, WB_*, IMM_*, ALUA_*, ALUB_*, ALU_*.
REQ-029 The ALU SHALL be a separate combinational sub-module rv_alu (a, b, alusel -> result); the register file remains inline.

Verification
REQ-030 Reset, then irwrite=pccen=pcwrite=1, pcsourse=0, mem_rdata=32'h00A00093 -> mem_addr=0, IR=32'h00A00093, PC=4, PCC=0.
REQ-031 IR=32'h00A00093 (addi x1,x0,10); asel=0, bsel=1, immsel=0, alusel=0, then wbsel=1, regwen=1 -> x1=10.
REQ-032 x1=5, x2=5; asel=0, bsel=0, alusel=SUB -> zero=1. Then ALUOUT=32'h40, pcsourse=1, pcwrite=1, asel=2, bsel=3 -> PC=32'h40.
REQ-033 x1=32'h8000_0000, x2=1: SLT -> 1, SLTU -> 0, SRA by 31 -> 32'hFFFF_FFFF, ADD with 32'h8000_0000 -> 0 with zero=1.
REQ-034 Store path: mem_wdata=rs2 data and mem_addr=ALUOUT. Load path: mdrwrite=1 with mem_rdata=32'hDEADBEEF, then wbsel=2, regwen=1, rd=3 -> x3=32'hDEADBEEF.
REQ-035 regwen=1 with rd=0 and write data 32'h1234 -> x0 reads 0. rst=1 mid-sequence -> all registers 0 on the next edge.
